// File: rtl/hue_wheel_if.sv
// Control and level bus of the hue wheel generator.
// master: the generator (takes enable/mode, drives levels and status).
// slave:  the consumer/controller side.
interface hue_wheel_if #(
  parameter int LW = 11
) ();
  logic          enable;
  logic [1:0]    mode;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_g;
  logic [LW-1:0] level_b;
  logic [2:0]    vertex;
  logic          step_pulse;
  logic          cycle_done;

  modport master (
    input  enable, mode,
    output level_r, level_g, level_b, vertex, step_pulse, cycle_done
  );

  modport slave (
    output enable, mode,
    input  level_r, level_g, level_b, vertex, step_pulse, cycle_done
  );
endinterface

// File: rtl/hue_wheel_gen.sv
// Hue wheel generator: produces R/G/B PWM duty levels that walk the colour
// wheel forward or backward, breathe white, or hold, one level step every
// TICK_DIV enabled clocks.
module hue_wheel_gen #(
  parameter int TICK_DIV  = 200000,
  parameter int LEVEL_MAX = 1200,
  parameter int STEP      = 12,
  parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
  input  logic      clk,
  input  logic      reset,
  hue_wheel_if.master bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LVL_MAX   = LW'(LEVEL_MAX);
  localparam logic [LW-1:0] LVL_STEP  = LW'(STEP);

  typedef enum logic [1:0] {
    M_HOLD      = 2'd0,
    M_WHEEL_FWD = 2'd1,
    M_WHEEL_REV = 2'd2,
    M_BREATHE   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  mode_t         mode_in;
  mode_t         active_q, active_d;
  mode_t         last_q, last_d;
  dir_t          dir_q, dir_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [LW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [2:0]    vtx_q, vtx_d;
  logic          step_q, step_d;
  logic          cyc_q, cyc_d;

  logic [2:0]    seg;
  logic          rising;
  logic [LW-1:0] chan_cur;
  logic [LW-1:0] chan_new;
  logic          at_end;

  assign mode_in = mode_t'(bus.mode);

  // Saturating add in LW+1 bits so the sum can never wrap.
  function automatic logic [LW-1:0] sat_up(input logic [LW-1:0] v);
    logic [LW:0] s;
    s = {1'b0, v} + {1'b0, LVL_STEP};
    if (s >= {1'b0, LVL_MAX}) return LVL_MAX;
    return s[LW-1:0];
  endfunction

  // Saturating subtract in LW+1 bits; a borrow into the top bit clamps to 0.
  function automatic logic [LW-1:0] sat_dn(input logic [LW-1:0] v);
    logic [LW:0] d;
    d = {1'b0, v} - {1'b0, LVL_STEP};
    if (d[LW]) return '0;
    return d[LW-1:0];
  endfunction

  function automatic logic [2:0] prev_vtx(input logic [2:0] v);
    return (v == 3'd0) ? 3'd5 : v - 3'd1;
  endfunction

  // State register: mode, tick count, levels, vertex, breathe direction, pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= M_WHEEL_FWD;
      last_q   <= M_WHEEL_FWD;
      dir_q    <= DIR_UP;
      tick_q   <= '0;
      r_q      <= LVL_MAX;
      g_q      <= '0;
      b_q      <= '0;
      vtx_q    <= '0;
      step_q   <= 1'b0;
      cyc_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      vtx_q    <= vtx_d;
      step_q   <= step_d;
      cyc_q    <= cyc_d;
    end
  end

  // Next state: mode switch/reload takes priority over stepping; a step is
  // applied on the tick-counter wrap.
  always_comb begin
    active_d = active_q;
    last_d   = last_q;
    dir_d    = dir_q;
    tick_d   = tick_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    vtx_d    = vtx_q;
    step_d   = 1'b0;
    cyc_d    = 1'b0;
    seg      = '0;
    rising   = 1'b0;
    chan_cur = '0;
    chan_new = '0;
    at_end   = 1'b0;

    if (mode_in != active_q) begin
      active_d = mode_in;
      tick_d   = '0;
      if (mode_in != M_HOLD) begin
        last_d = mode_in;
        // Returning from HOLD to the mode that was running resumes in place.
        if (!(active_q == M_HOLD && mode_in == last_q)) begin
          vtx_d = '0;
          if (mode_in == M_BREATHE) begin
            r_d   = '0;
            g_d   = '0;
            b_d   = '0;
            dir_d = DIR_UP;
          end else begin
            r_d = LVL_MAX;
            g_d = '0;
            b_d = '0;
          end
        end
      end
    end else if (bus.enable && active_q != M_HOLD) begin
      if (tick_q != TICK_LAST) begin
        tick_d = tick_q + 1'b1;
      end else begin
        tick_d = '0;
        step_d = 1'b1;
        if (active_q == M_BREATHE) begin
          // All three channels are kept equal, so red stands for all of them.
          if (dir_q == DIR_UP) begin
            chan_new = sat_up(r_q);
            if (chan_new == LVL_MAX) dir_d = DIR_DOWN;
          end else begin
            chan_new = sat_dn(r_q);
            if (chan_new == '0) begin
              dir_d = DIR_UP;
              cyc_d = 1'b1;
            end
          end
          r_d = chan_new;
          g_d = chan_new;
          b_d = chan_new;
        end else begin
          // Reverse replays the segment leading into the current vertex,
          // inverted: same channel, opposite direction.
          seg    = (active_q == M_WHEEL_FWD) ? vtx_q : prev_vtx(vtx_q);
          rising = ~seg[0] ^ (active_q == M_WHEEL_REV);
          case (seg)
            3'd0, 3'd3: chan_cur = g_q;
            3'd1, 3'd4: chan_cur = r_q;
            default:    chan_cur = b_q;
          endcase
          chan_new = rising ? sat_up(chan_cur) : sat_dn(chan_cur);
          at_end   = rising ? (chan_new == LVL_MAX) : (chan_new == '0);
          case (seg)
            3'd0, 3'd3: g_d = chan_new;
            3'd1, 3'd4: r_d = chan_new;
            default:    b_d = chan_new;
          endcase
          if (at_end) begin
            if (active_q == M_WHEEL_FWD) begin
              vtx_d = (vtx_q == 3'd5) ? 3'd0 : vtx_q + 3'd1;
              cyc_d = (vtx_q == 3'd5);
            end else begin
              vtx_d = prev_vtx(vtx_q);
              cyc_d = (vtx_q == 3'd1);
            end
          end
        end
      end
    end
  end

  assign bus.level_r    = r_q;
  assign bus.level_g    = g_q;
  assign bus.level_b    = b_q;
  assign bus.vertex     = vtx_q;
  assign bus.step_pulse = step_q;
  assign bus.cycle_done = cyc_q;

endmodule

// File: tb/tb_hue_wheel_gen.sv
// Bench for hue_wheel_gen: two instances (LEVEL_MAX 12 and 10, STEP 4,
// TICK_DIV 4) checked every cycle against a colour-target model, plus
// literal expectations at known edges.
module tb_hue_wheel_gen;

  localparam int TD  = 4;
  localparam int M1  = 12;
  localparam int M2  = 10;
  localparam int S   = 4;
  localparam int LW1 = $clog2(M1 + 1);
  localparam int LW2 = $clog2(M2 + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hue_wheel_if #(.LW(LW1)) if1 ();
  hue_wheel_if #(.LW(LW2)) if2 ();

  hue_wheel_gen #(.TICK_DIV(TD), .LEVEL_MAX(M1), .STEP(S)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  hue_wheel_gen #(.TICK_DIV(TD), .LEVEL_MAX(M2), .STEP(S)) dut2 (
    .clk(clk), .reset(reset), .bus(if2)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    int am;
    int last;
    int tick;
    int r;
    int g;
    int b;
    int v;
    int up;
    int sp;
    int cd;
  } ms_t;

  ms_t m1, m2;

  function automatic ms_t ms_reset(int m);
    ms_t n;
    n.am = 1; n.last = 1; n.tick = 0;
    n.r = m; n.g = 0; n.b = 0; n.v = 0;
    n.up = 1; n.sp = 0; n.cd = 0;
    return n;
  endfunction

  // Colour at wheel vertex vtx for channel ch (0=R,1=G,2=B), as full/zero.
  function automatic int colour(int vtx, int ch, int m);
    logic [2:0] k;
    case (vtx)
      0: k = 3'b100;
      1: k = 3'b110;
      2: k = 3'b010;
      3: k = 3'b011;
      4: k = 3'b001;
      default: k = 3'b101;
    endcase
    return k[2-ch] ? m : 0;
  endfunction

  function automatic int toward(int cur, int tgt);
    if (cur < tgt) return (cur + S > tgt) ? tgt : cur + S;
    if (cur > tgt) return (cur - S < tgt) ? tgt : cur - S;
    return cur;
  endfunction

  // One clock edge of the model: each step moves every channel toward the
  // colour of the target vertex (or toward white/black in breathe).
  function automatic ms_t model_edge(ms_t s, int mode, int en, int m);
    ms_t n;
    int t;
    n = s;
    n.sp = 0;
    n.cd = 0;
    if (mode != s.am) begin
      n.am = mode;
      n.tick = 0;
      if (mode != 0) begin
        if (!(s.am == 0 && mode == s.last)) begin
          n.v = 0;
          if (mode == 3) begin
            n.r = 0; n.g = 0; n.b = 0; n.up = 1;
          end else begin
            n.r = m; n.g = 0; n.b = 0;
          end
        end
        n.last = mode;
      end
    end else if (en != 0 && s.am != 0) begin
      n.tick = s.tick + 1;
      if (n.tick == TD) begin
        n.tick = 0;
        n.sp = 1;
        if (s.am == 3) begin
          t = (s.up != 0) ? m : 0;
          n.r = toward(s.r, t);
          n.g = toward(s.g, t);
          n.b = toward(s.b, t);
          if (n.r == t) begin
            n.up = (s.up != 0) ? 0 : 1;
            if (s.up == 0) n.cd = 1;
          end
        end else begin
          t = (s.am == 1) ? (s.v + 1) % 6 : (s.v + 5) % 6;
          n.r = toward(s.r, colour(t, 0, m));
          n.g = toward(s.g, colour(t, 1, m));
          n.b = toward(s.b, colour(t, 2, m));
          if (n.r == colour(t, 0, m) && n.g == colour(t, 1, m) && n.b == colour(t, 2, m)) begin
            n.v = t;
            if (t == 0) n.cd = 1;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 <= ms_reset(M1);
      m2 <= ms_reset(M2);
    end else begin
      m1 <= model_edge(m1, int'(if1.mode), int'(if1.enable), M1);
      m2 <= model_edge(m2, int'(if2.mode), int'(if2.enable), M2);
    end
  end

  task automatic cmp_one(string nm, int r, int g, int b, int v, int sp, int cd, ms_t e);
    checks++;
    if (r == e.r && g == e.g && b == e.b && v == e.v && sp == e.sp && cd == e.cd)
      passes++;
    else
      $display("FAIL %s @%0t: got r=%0d g=%0d b=%0d v=%0d sp=%0d cd=%0d, expected r=%0d g=%0d b=%0d v=%0d sp=%0d cd=%0d",
               nm, $time, r, g, b, v, sp, cd, e.r, e.g, e.b, e.v, e.sp, e.cd);
  endtask

  task automatic cmp_all();
    cmp_one("dut1_vs_model", int'(if1.level_r), int'(if1.level_g), int'(if1.level_b),
            int'(if1.vertex), int'(if1.step_pulse), int'(if1.cycle_done), m1);
    cmp_one("dut2_vs_model", int'(if2.level_r), int'(if2.level_g), int'(if2.level_b),
            int'(if2.vertex), int'(if2.step_pulse), int'(if2.cycle_done), m2);
  endtask

  task automatic lit(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  task automatic edge1();
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    reset = 1'b1;
    if1.enable = 1'b1; if1.mode = 2'd1;
    if2.enable = 1'b1; if2.mode = 2'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_all();
    lit("rst_r", int'(if1.level_r), 12);
    lit("rst_g", int'(if1.level_g), 0);
    lit("rst_b", int'(if1.level_b), 0);
    lit("rst_v", int'(if1.vertex), 0);
    lit("rst_sp", int'(if1.step_pulse), 0);
    lit("rst_cd", int'(if1.cycle_done), 0);

    // Forward wheel from reset; dut2 exercises the clamped partial step.
    for (int e = 1; e <= 73; e++) begin
      edge1();
      case (e)
        3:  begin lit("fwd_g_e3", int'(if1.level_g), 0); lit("fwd_sp_e3", int'(if1.step_pulse), 0); end
        4:  begin lit("fwd_g_e4", int'(if1.level_g), 4); lit("fwd_sp_e4", int'(if1.step_pulse), 1);
                  lit("clamp_g_e4", int'(if2.level_g), 4); end
        5:  lit("fwd_sp_e5", int'(if1.step_pulse), 0);
        8:  begin lit("fwd_g_e8", int'(if1.level_g), 8); lit("clamp_g_e8", int'(if2.level_g), 8); end
        11: lit("clamp_v_e11", int'(if2.vertex), 0);
        12: begin lit("fwd_g_e12", int'(if1.level_g), 12); lit("fwd_v_e12", int'(if1.vertex), 1);
                  lit("clamp_g_e12", int'(if2.level_g), 10); lit("clamp_v_e12", int'(if2.vertex), 1); end
        16: lit("clamp_r_e16", int'(if2.level_r), 6);
        20: lit("clamp_r_e20", int'(if2.level_r), 2);
        24: begin lit("clamp_r_e24", int'(if2.level_r), 0); lit("clamp_v_e24", int'(if2.vertex), 2); end
        71: lit("fwd_cd_e71", int'(if1.cycle_done), 0);
        72: begin lit("fwd_cd_e72", int'(if1.cycle_done), 1); lit("fwd_v_e72", int'(if1.vertex), 0);
                  lit("fwd_r_e72", int'(if1.level_r), 12); lit("fwd_g_e72", int'(if1.level_g), 0); end
        73: lit("fwd_cd_e73", int'(if1.cycle_done), 0);
        default: ;
      endcase
    end

    // Reverse wheel.
    if1.mode = 2'd2;
    for (int e = 1; e <= 73; e++) begin
      edge1();
      case (e)
        1:  begin lit("rev_load_r", int'(if1.level_r), 12); lit("rev_load_b", int'(if1.level_b), 0);
                  lit("rev_load_v", int'(if1.vertex), 0); lit("rev_load_sp", int'(if1.step_pulse), 0); end
        5:  begin lit("rev_b_e5", int'(if1.level_b), 4); lit("rev_sp_e5", int'(if1.step_pulse), 1); end
        13: begin lit("rev_b_e13", int'(if1.level_b), 12); lit("rev_v_e13", int'(if1.vertex), 5); end
        72: lit("rev_cd_e72", int'(if1.cycle_done), 0);
        73: begin lit("rev_cd_e73", int'(if1.cycle_done), 1); lit("rev_v_e73", int'(if1.vertex), 0);
                  lit("rev_r_e73", int'(if1.level_r), 12); lit("rev_b_e73", int'(if1.level_b), 0); end
        default: ;
      endcase
    end

    // White breathe.
    if1.mode = 2'd3;
    for (int e = 1; e <= 49; e++) begin
      edge1();
      case (e)
        1:  begin lit("br_load_r", int'(if1.level_r), 0); lit("br_load_v", int'(if1.vertex), 0); end
        5:  lit("br_e5", int'(if1.level_g), 4);
        9:  lit("br_e9", int'(if1.level_b), 8);
        13: lit("br_e13", int'(if1.level_r), 12);
        17: lit("br_e17", int'(if1.level_r), 8);
        21: begin lit("br_e21", int'(if1.level_r), 4); lit("br_cd_e21", int'(if1.cycle_done), 0); end
        25: begin lit("br_e25", int'(if1.level_r), 0); lit("br_cd_e25", int'(if1.cycle_done), 1); end
        48: lit("br_cd_e48", int'(if1.cycle_done), 0);
        49: lit("br_cd_e49", int'(if1.cycle_done), 1);
        default: ;
      endcase
    end

    // Hold and resume.
    if1.mode = 2'd1;
    for (int e = 1; e <= 9; e++) begin
      edge1();
      if (e == 1) begin lit("fwd2_load_r", int'(if1.level_r), 12); lit("fwd2_load_g", int'(if1.level_g), 0); end
      if (e == 9) lit("fwd2_g_e9", int'(if1.level_g), 8);
    end
    if1.mode = 2'd0;
    for (int e = 1; e <= 20; e++) begin
      edge1();
      lit("hold_g", int'(if1.level_g), 8);
      lit("hold_sp", int'(if1.step_pulse), 0);
    end
    if1.mode = 2'd1;
    for (int e = 1; e <= 5; e++) begin
      edge1();
      if (e == 1) lit("resume_g_e1", int'(if1.level_g), 8);
      if (e == 4) lit("resume_g_e4", int'(if1.level_g), 8);
      if (e == 5) begin lit("resume_g_e5", int'(if1.level_g), 12); lit("resume_v_e5", int'(if1.vertex), 1); end
    end

    // Enable low mid-interval, then mode change while disabled.
    repeat (2) edge1();
    if1.enable = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge1();
      lit("dis_r", int'(if1.level_r), 12);
      lit("dis_sp", int'(if1.step_pulse), 0);
    end
    if1.enable = 1'b1;
    edge1();
    lit("en_sp_e1", int'(if1.step_pulse), 0);
    edge1();
    lit("en_sp_e2", int'(if1.step_pulse), 1);
    lit("en_r_e2", int'(if1.level_r), 8);
    if1.enable = 1'b0;
    if1.mode = 2'd3;
    for (int e = 1; e <= 3; e++) begin
      edge1();
      lit("dis_mode_r", int'(if1.level_r), 0);
      lit("dis_mode_g", int'(if1.level_g), 0);
    end
    if1.enable = 1'b1;
    if1.mode = 2'd1;
    for (int e = 1; e <= 6; e++) begin
      edge1();
      if (e == 1) begin lit("rel_r", int'(if1.level_r), 12); lit("rel_v", int'(if1.vertex), 0); end
      if (e == 5) lit("rel_g_e5", int'(if1.level_g), 4);
    end

    // Asynchronous reset mid-segment, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    lit("arst_r", int'(if1.level_r), 12);
    lit("arst_g", int'(if1.level_g), 0);
    lit("arst_b", int'(if1.level_b), 0);
    lit("arst_v", int'(if1.vertex), 0);
    lit("arst_r2", int'(if2.level_r), 10);
    edge1();
    reset = 1'b0;
    repeat (6) edge1();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
